ct_loader: RTL and testbench
============================

Name: ct_loader

Overview:
- Upstream feeder for the ARC4 cracker (doublecrack).
- Accepts a byte stream over a valid/ready handshake: the first byte is the length L, followed by L ciphertext bytes.
- Writes the stream into ct_mem as a length-prefixed string: length at address 0, data at 1..L.
- Then pulses the cracker's en, waits for the crack to finish, and latches key/key_valid as the result.

Parameters:
- CT_AW, 8: ct_mem address width; the length byte limits L to 2^CT_AW-1 = 255.
- KEY_W, 24: key width, matching the cracker's key output.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  8  upstream byte
- in_ready  out  1  loader can accept a byte
- ct_mem_sel  out  1  1 = loader owns the ct_mem port (top-level mux select); 0 = cracker owns it
- ct_addr  out  CT_AW  ct_mem write address
- ct_wrdata  out  8  ct_mem write data
- ct_wren  out  1  ct_mem write enable
- crk_en  out  1  one-cycle start pulse to the cracker
- crk_rdy  in  1  cracker ready/idle
- crk_key  in  KEY_W  cracker key result
- crk_key_valid  in  1  cracker found a key
- result_key  out  KEY_W  latched key
- result_found  out  1  latched key_valid
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level: result registers valid

Behaviour:
- Reset (asynchronous, any state, including mid-load or mid-crack): state=IDLE.
  - in_ready=1, ct_mem_sel=1.
  - ct_wren=0, crk_en=0, done=0, busy=0.
  - ct_addr=0, ct_wrdata=0, result_key=0, result_found=0.
  - Length and byte counters are cleared.
- Handshake:
  - A byte is accepted on any clk edge with in_valid & in_ready.
  - in_ready is combinationally 1 only in IDLE and LOAD.
- Write latency:
  - An accepted byte appears on ct_addr/ct_wrdata with ct_wren=1 exactly one cycle after acceptance.
  - ct_wren lasts one cycle per byte; back-to-back accepts produce back-to-back writes.
- IDLE:
  - An accepted byte is the length L and is written to address 0; the counter is set to 1.
  - L>0 -> LOAD.
  - L=0 -> START, entered the cycle after the address-0 write is issued.
- LOAD:
  - The k-th data byte (k=1..L) is written to address k.
  - After the L-th byte is accepted -> START. in_ready drops in that same cycle, so byte L+1 is never accepted.
  - in_valid low stalls with no writes and no timeout.
- START:
  - ct_mem_sel=0 from START onward.
  - Entered only after the final write has been issued.
  - Waits for crk_rdy=1, then drives crk_en=1 for exactly one cycle -> RUN.
- RUN:
  - The cracker must first be observed with crk_rdy=0; a seen_busy flag is set on that cycle.
  - Once seen_busy is set, the first cycle with crk_rdy=1 latches result_key<=crk_key and result_found<=crk_key_valid -> DONE.
  - crk_rdy=1 before any crk_rdy=0 is not treated as completion; this covers the cracker's deassert latency.
- DONE:
  - done=1, busy=0, in_ready=0; results held.
  - in_valid=1 -> IDLE with done cleared, next cycle. That byte is not consumed; it is accepted in IDLE on the following cycle as the new length.
- Widths and limits:
  - The address counter is CT_AW bits; L≤255, so the maximum address is 255 and never wraps.
  - Length is unsigned; no error path.
- Simultaneous events:
  - In START, crk_en is never issued while a write is pending.
  - In RUN, in_valid is ignored.

Test Plan:
- Reset, then stream 0x03, 0xAA, 0xBB, 0xCC back-to-back -> writes (0,03), (1,AA), (2,BB), (3,CC) on consecutive cycles, each 1 cycle after acceptance; in_ready=0 after 0xCC; ct_mem_sel falls; one crk_en pulse.
- Same stream with in_valid gapped every other cycle -> identical memory contents, no spurious ct_wren, addresses contiguous.
- Cracker model: rdy low for 2 cycles after en, then rdy=1 with key=24'h000018, key_valid=1 -> result_key=000018, result_found=1, done=1. Repeat with key_valid=0 -> result_found=0.
- Cracker model holds rdy=1 for 3 cycles after en before dropping -> no early completion; result latched only on the later rdy rise.
- Length 0x00 -> single write (0,00), immediate START, crk_en pulse. Length 0xFF with 255 bytes -> last write to address 0xFF, no wrap.
- Assert rst_n=0 mid-LOAD (after 2 of 5 bytes) and mid-RUN -> all outputs return to reset values asynchronously; a new stream loads from address 0. In DONE, in_valid=1 -> returns to IDLE and the next length is accepted.

Source files
------------

// File: rtl/ct_loader.sv
// ct_loader: receives a length-prefixed byte stream, writes it into ct_mem,
// starts the ARC4 cracker, waits for it to finish and holds its result.
module ct_loader #(
  parameter int CT_AW = 8,
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             ct_mem_sel,
  output logic [CT_AW-1:0] ct_addr,
  output logic [7:0]       ct_wrdata,
  output logic             ct_wren,
  output logic             crk_en,
  input  logic             crk_rdy,
  input  logic [KEY_W-1:0] crk_key,
  input  logic             crk_key_valid,
  output logic [KEY_W-1:0] result_key,
  output logic             result_found,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CT_AW-1:0] len_r;
  logic [CT_AW-1:0] cnt_r;
  logic             seen_busy_r;
  logic             accept_s;
  logic             launch_s;
  logic             finish_s;

  // Next-state decode plus the strobes that steer the datapath registers.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    ct_mem_sel  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept_s    = 1'b0;
    launch_s    = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        in_ready   = 1'b1;
        ct_mem_sel = 1'b1;
        accept_s   = in_valid;
        if (in_valid) begin
          // A zero length skips LOAD; START still waits for the write to retire.
          if (in_data == 8'd0) begin
            state_nxt_s = S_START;
          end else begin
            state_nxt_s = S_LOAD;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        in_ready   = 1'b1;
        ct_mem_sel = 1'b1;
        busy       = 1'b1;
        accept_s   = in_valid;
        // Leaving on the last byte drops in_ready so byte L+1 is never taken.
        if (in_valid && (cnt_r == len_r)) begin
          state_nxt_s = S_START;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_START: begin
        busy = 1'b1;
        // Hold off the start pulse until the final ct_mem write has been issued.
        if (!ct_wren && crk_rdy) begin
          launch_s    = 1'b1;
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // Only a ready seen after the cracker went busy marks completion.
        if (seen_busy_r && crk_rdy) begin
          finish_s    = 1'b1;
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // The waking byte is not consumed here; IDLE accepts it next cycle.
        if (in_valid) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write port, length/byte counters and the cracker start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_wren   <= 1'b0;
      ct_addr   <= {CT_AW{1'b0}};
      ct_wrdata <= 8'd0;
      len_r     <= {CT_AW{1'b0}};
      cnt_r     <= {CT_AW{1'b0}};
      crk_en    <= 1'b0;
    end else begin
      ct_wren <= accept_s;
      crk_en  <= launch_s;
      if (accept_s) begin
        ct_wrdata <= in_data;
        if (state_r == S_IDLE) begin
          ct_addr <= {CT_AW{1'b0}};
          len_r   <= CT_AW'(in_data);
          cnt_r   <= CT_AW'(1);
        end else begin
          ct_addr <= cnt_r;
          cnt_r   <= cnt_r + CT_AW'(1);
        end
      end
    end
  end

  // Track that the cracker has gone busy during the current run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_busy_r <= 1'b0;
    end else if (state_r != S_RUN) begin
      seen_busy_r <= 1'b0;
    end else if (!crk_rdy) begin
      seen_busy_r <= 1'b1;
    end else begin
      seen_busy_r <= seen_busy_r;
    end
  end

  // Capture the cracker result on completion and hold it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_key   <= {KEY_W{1'b0}};
      result_found <= 1'b0;
    end else if (finish_s) begin
      result_key   <= crk_key;
      result_found <= crk_key_valid;
    end else begin
      result_key   <= result_key;
      result_found <= result_found;
    end
  end

endmodule

// File: tb/tb_ct_loader.sv
// Directed bench for ct_loader with a write scoreboard and a scripted cracker.
module tb_ct_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ct_mem_sel;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_wrdata;
  logic        ct_wren;
  logic        crk_en;
  logic        crk_rdy;
  logic [23:0] crk_key;
  logic        crk_key_valid;
  logic [23:0] result_key;
  logic        result_found;
  logic        busy;
  logic        done;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_addr;
  logic        acc_prev;
  logic [15:0] got_w;

  ct_loader #(.CT_AW(8), .KEY_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ct_mem_sel(ct_mem_sel), .ct_addr(ct_addr),
    .ct_wrdata(ct_wrdata), .ct_wren(ct_wren), .crk_en(crk_en),
    .crk_rdy(crk_rdy), .crk_key(crk_key), .crk_key_valid(crk_key_valid),
    .result_key(result_key), .result_found(result_found), .busy(busy),
    .done(done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some bounded wait is still missed.
  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: latency against the previous accept, contents against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_prev = 1'b0;
    end else begin
      if (ct_wren || acc_prev) check("wr_latency", ct_wren, acc_prev);
      if (ct_wren) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", exp_q.size(), 1);
        end else begin
          got_w = exp_q.pop_front();
          check("wr_addr_data", {ct_addr, ct_wrdata}, got_w);
        end
      end
      acc_prev = in_valid & in_ready;
    end
  end

  task automatic check_rst(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_mem_sel"}, ct_mem_sel, 1);
    check({tag, "_wren"}, ct_wren, 0);
    check({tag, "_crk_en"}, crk_en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr"}, ct_addr, 0);
    check({tag, "_wrdata"}, ct_wrdata, 0);
    check({tag, "_result_key"}, result_key, 0);
    check({tag, "_result_found"}, result_found, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({exp_addr, b});
        exp_addr = exp_addr + 8'd1;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("accept_timeout", ok, 1);
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stream(input int len, input int nbytes, input logic [7:0] base,
                        input logic [7:0] step, input bit gap);
    logic [7:0] b;
    exp_addr = 8'd0;
    send_byte(8'(len), gap);
    check("done_cleared", done, 0);
    for (int k = 1; k <= nbytes; k++) begin
      b = 8'(base + 8'(k - 1) * step);
      send_byte(b, gap);
    end
  endtask

  task automatic run_crack(input int hold, input int low, input logic [23:0] key, input bit kv);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (crk_en) seen = 1'b1;
    end
    check("crk_en_seen", seen, 1);
    check("wren_at_en", ct_wren, 0);
    check("mem_sel_run", ct_mem_sel, 0);
    check("busy_run", busy, 1);
    @(posedge clk);
    #1;
    check("crk_en_one_cycle", crk_en, 0);
    crk_key       = 24'hBAD000;
    crk_key_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("no_early_done", done, 0);
      @(posedge clk);
      #1;
    end
    crk_rdy = 1'b0;
    repeat (low) @(posedge clk);
    #1;
    crk_key       = key;
    crk_key_valid = kv;
    crk_rdy       = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("result_key", result_key, key);
    check("result_found", result_found, kv);
    check("busy_done", busy, 0);
    check("in_ready_done", in_ready, 0);
    check("sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_data       = 8'd0;
    crk_rdy       = 1'b1;
    crk_key       = 24'd0;
    crk_key_valid = 1'b0;
    exp_addr      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_rst("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-byte stream back-to-back, then found key.
    stream(3, 3, 8'hAA, 8'h11, 1'b0);
    check("in_ready_after_last", in_ready, 0);
    check("mem_sel_after_last", ct_mem_sel, 0);
    run_crack(0, 2, 24'h000018, 1'b1);

    // Same stream with gaps, cracker reports no key.
    stream(3, 3, 8'hAA, 8'h11, 1'b1);
    run_crack(0, 2, 24'h123456, 1'b0);

    // Cracker stays ready for 3 cycles after en before going busy.
    stream(2, 2, 8'h11, 8'h11, 1'b0);
    run_crack(3, 2, 24'h00ABCD, 1'b1);

    // Zero length: single write to address 0, then straight to the crack.
    stream(0, 0, 8'h00, 8'h00, 1'b0);
    run_crack(0, 1, 24'h000001, 1'b1);

    // Maximum length: last write lands on address 0xFF.
    stream(255, 255, 8'h01, 8'h03, 1'b0);
    check("max_addr", ct_addr, 8'hFF);
    run_crack(0, 2, 24'hFEDCBA, 1'b1);

    // Reset in the middle of a load.
    stream(5, 2, 8'h40, 8'h01, 1'b0);
    rst_n = 1'b0;
    #1;
    check_rst("rst_load");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh load from address 0, then reset while the cracker is running.
    stream(2, 2, 8'h77, 8'h11, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        @(negedge clk);
        if (crk_en) seen = 1'b1;
      end
      check("run_rst_en_seen", seen, 1);
    end
    check("sb_empty_run", exp_q.size(), 0);
    @(posedge clk);
    #1;
    crk_rdy = 1'b0;
    @(posedge clk);
    #1;
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check_rst("rst_run");
    crk_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Recovery load after reset.
    stream(1, 1, 8'h99, 8'h00, 1'b0);
    run_crack(0, 3, 24'h0A0B0C, 1'b0);

    // From DONE a new length wakes the loader and is accepted in IDLE.
    stream(1, 1, 8'h5C, 8'h00, 1'b1);
    run_crack(1, 1, 24'h00C0DE, 1'b1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
